// File: rtl/hdmi_packet_if.sv
// Data-island packet bus between the packet sources, the arbiter and the TMDS packer.
// The slave modport is the arbiter's side; the master modport is the source/sink side.
interface hdmi_packet_if;
    logic             clk_audio_counter_wrap;
    logic [23:0]      acr_header;
    logic [3:0][55:0] acr_sub;
    logic             audio_req;
    logic             audio_ack;
    logic [23:0]      audio_header;
    logic [3:0][55:0] audio_sub;
    logic [23:0]      avi_header;
    logic [3:0][55:0] avi_sub;
    logic [23:0]      aif_header;
    logic [3:0][55:0] aif_sub;
    logic             frame_start;
    logic             packet_enable;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic [2:0]       packet_type;
    logic             acr_overflow;
    logic [7:0]       acr_drop_count;

    modport slave (
        input  clk_audio_counter_wrap, acr_header, acr_sub,
        input  audio_req, audio_header, audio_sub,
        input  avi_header, avi_sub, aif_header, aif_sub,
        input  frame_start, packet_enable,
        output audio_ack, header, sub, packet_type, acr_overflow, acr_drop_count
    );

    modport master (
        output clk_audio_counter_wrap, acr_header, acr_sub,
        output audio_req, audio_header, audio_sub,
        output avi_header, avi_sub, aif_header, aif_sub,
        output frame_start, packet_enable,
        input  audio_ack, header, sub, packet_type, acr_overflow, acr_drop_count
    );
endinterface

// File: rtl/hdmi_packet_arbiter.sv
// Data-island packet selector: fixed priority ACR > audio > AVI > AIF > null, one registered packet per slot.
// Define HDMI_ACR_DROP_COUNT_EN to build the saturating count of lost ACR events.
module hdmi_packet_arbiter #(
    parameter int AVI_PERIOD    = 1,
    parameter int AUD_IF_PERIOD = 1
) (
    input  logic         clk_pixel,
    input  logic         reset,
    hdmi_packet_if.slave bus
);
    typedef enum logic [2:0] {
        PKT_NULL  = 3'd0,
        PKT_ACR   = 3'd1,
        PKT_AUDIO = 3'd2,
        PKT_AVI   = 3'd3,
        PKT_AIF   = 3'd4
    } pkt_t;

    localparam logic [3:0] AVI_LAST = 4'(AVI_PERIOD - 1);
    localparam logic [3:0] AIF_LAST = 4'(AUD_IF_PERIOD - 1);

    logic       armed, wrap_q;
    logic       acr_pending, avi_pending, aif_pending;
    logic [3:0] avi_cnt, aif_cnt;
    logic       acr_evt, acr_lost, avi_due, aif_due;
    pkt_t       sel;
    logic [23:0]      nxt_header;
    logic [3:0][55:0] nxt_sub;

    // armed stays low for the first cycle out of reset so wrap_q can pick up
    // the current wrap level without it being mistaken for a toggle.
    assign acr_evt  = armed & (bus.clk_audio_counter_wrap ^ wrap_q);
    assign acr_lost = acr_evt & acr_pending & ~(bus.packet_enable & (sel == PKT_ACR));
    assign avi_due  = bus.frame_start & (avi_cnt == AVI_LAST);
    assign aif_due  = bus.frame_start & (aif_cnt == AIF_LAST);

    always_comb begin
        sel        = PKT_NULL;
        nxt_header = 24'h000000;
        nxt_sub    = '0;
        if (acr_pending) begin
            sel        = PKT_ACR;
            nxt_header = bus.acr_header;
            nxt_sub    = bus.acr_sub;
        end else if (bus.audio_req) begin
            sel        = PKT_AUDIO;
            nxt_header = bus.audio_header;
            nxt_sub    = bus.audio_sub;
        end else if (avi_pending) begin
            sel        = PKT_AVI;
            nxt_header = bus.avi_header;
            nxt_sub    = bus.avi_sub;
        end else if (aif_pending) begin
            sel        = PKT_AIF;
            nxt_header = bus.aif_header;
            nxt_sub    = bus.aif_sub;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            armed  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            armed  <= 1'b1;
            wrap_q <= bus.clk_audio_counter_wrap;
        end
    end

    // A new request arriving on the serving edge wins over the clear.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            acr_pending      <= 1'b0;
            avi_pending      <= 1'b1;
            aif_pending      <= 1'b1;
            avi_cnt          <= 4'd0;
            aif_cnt          <= 4'd0;
            bus.acr_overflow <= 1'b0;
        end else begin
            if (acr_evt)
                acr_pending <= 1'b1;
            else if (bus.packet_enable && sel == PKT_ACR)
                acr_pending <= 1'b0;
            if (avi_due)
                avi_pending <= 1'b1;
            else if (bus.packet_enable && sel == PKT_AVI)
                avi_pending <= 1'b0;
            if (aif_due)
                aif_pending <= 1'b1;
            else if (bus.packet_enable && sel == PKT_AIF)
                aif_pending <= 1'b0;
            if (bus.frame_start) begin
                avi_cnt <= avi_due ? 4'd0 : avi_cnt + 4'd1;
                aif_cnt <= aif_due ? 4'd0 : aif_cnt + 4'd1;
            end
            if (acr_lost)
                bus.acr_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            bus.header      <= 24'h000000;
            bus.sub         <= '0;
            bus.packet_type <= 3'd0;
            bus.audio_ack   <= 1'b0;
        end else begin
            bus.audio_ack <= bus.packet_enable && (sel == PKT_AUDIO);
            if (bus.packet_enable) begin
                bus.header      <= nxt_header;
                bus.sub         <= nxt_sub;
                bus.packet_type <= sel;
            end
        end
    end

`ifdef HDMI_ACR_DROP_COUNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset)
            drop_cnt <= 8'h00;
        else if (acr_lost && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end

    assign bus.acr_drop_count = drop_cnt;
`else
    assign bus.acr_drop_count = 8'h00;
`endif
endmodule

// File: tb/tb_hdmi_packet_arbiter.sv
// Directed bench for hdmi_packet_arbiter (AVI_PERIOD=3, AUD_IF_PERIOD=1).
module tb_hdmi_packet_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;

    hdmi_packet_if pif ();

    hdmi_packet_arbiter #(.AVI_PERIOD(3), .AUD_IF_PERIOD(1)) dut (
        .clk_pixel (clk),
        .reset     (reset),
        .bus       (pif)
    );

    always #5 clk = ~clk;

    localparam logic [23:0] ACR_H = 24'h000001;
    localparam logic [23:0] AUD_H = 24'h000002;
    localparam logic [23:0] AVI_H = 24'h0D0282;
    localparam logic [23:0] AIF_H = 24'h0A0184;
    localparam logic [3:0][55:0] ACR_S = {56'h11111111111111, 56'h12121212121212, 56'h13131313131313, 56'h14141414141414};
    localparam logic [3:0][55:0] AUD_S = {56'h21000000000021, 56'h22000000000022, 56'h23000000000023, 56'h24000000000024};
    localparam logic [3:0][55:0] AVI_S = {56'h31313131313131, 56'h32000000000000, 56'h33000000000000, 56'h34000000000000};
    localparam logic [3:0][55:0] AIF_S = {56'h41000000000000, 56'h42424242424242, 56'h43000000000000, 56'h44000000000000};

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_enable();
        pif.packet_enable = 1'b1;
        tick(1);
        pif.packet_enable = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        total++; if (pif.header !== 24'h0) $display("FAIL reset_header got %h want 000000", pif.header); else passed++;
        total++; if (pif.sub !== '0) $display("FAIL reset_sub got %h want 0", pif.sub); else passed++;
        total++; if (pif.packet_type !== 3'd0) $display("FAIL reset_type got %0d want 0", pif.packet_type); else passed++;
        total++; if ({pif.audio_ack, pif.acr_overflow, pif.acr_drop_count} !== 10'd0)
            $display("FAIL reset_flags got ack=%b ovf=%b drop=%0d want 0/0/0", pif.audio_ack, pif.acr_overflow, pif.acr_drop_count);
        else passed++;
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_infoframes();
        pulse_enable();
        total++; if (pif.packet_type !== 3'd3 || pif.header !== AVI_H || pif.sub !== AVI_S)
            $display("FAIL if_avi got type=%0d hdr=%h want 3/%h", pif.packet_type, pif.header, AVI_H);
        else passed++;
        pulse_enable();
        total++; if (pif.packet_type !== 3'd4 || pif.header !== AIF_H || pif.sub !== AIF_S)
            $display("FAIL if_aif got type=%0d hdr=%h want 4/%h", pif.packet_type, pif.header, AIF_H);
        else passed++;
        tick(3);
        total++; if (pif.packet_type !== 3'd4 || pif.header !== AIF_H)
            $display("FAIL if_hold got type=%0d hdr=%h want 4/%h", pif.packet_type, pif.header, AIF_H);
        else passed++;
        pulse_enable();
        total++; if (pif.packet_type !== 3'd0 || pif.header !== 24'h0 || pif.sub !== '0)
            $display("FAIL if_null got type=%0d hdr=%h want 0/000000", pif.packet_type, pif.header);
        else passed++;
    endtask

    task automatic test_acr();
        pif.clk_audio_counter_wrap = ~pif.clk_audio_counter_wrap;
        tick(5);
        pulse_enable();
        total++; if (pif.packet_type !== 3'd1 || pif.header !== ACR_H || pif.sub !== ACR_S)
            $display("FAIL acr_serve got type=%0d hdr=%h want 1/%h", pif.packet_type, pif.header, ACR_H);
        else passed++;
        total++; if (pif.acr_overflow !== 1'b0) $display("FAIL acr_no_ovf got %b want 0", pif.acr_overflow); else passed++;
    endtask

    task automatic test_audio();
        pif.audio_req = 1'b1;
        pif.clk_audio_counter_wrap = ~pif.clk_audio_counter_wrap;
        tick(2);
        pulse_enable();
        total++; if (pif.packet_type !== 3'd1 || pif.audio_ack !== 1'b0)
            $display("FAIL aud_acr_first got type=%0d ack=%b want 1/0", pif.packet_type, pif.audio_ack);
        else passed++;
        pulse_enable();
        total++; if (pif.packet_type !== 3'd2 || pif.header !== AUD_H || pif.sub !== AUD_S || pif.audio_ack !== 1'b1)
            $display("FAIL aud_serve got type=%0d hdr=%h ack=%b want 2/%h/1", pif.packet_type, pif.header, pif.audio_ack, AUD_H);
        else passed++;
        pif.audio_req = 1'b0;
        tick(1);
        total++; if (pif.audio_ack !== 1'b0) $display("FAIL aud_ack_pulse got %b want 0", pif.audio_ack); else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] want_drop;
`ifdef HDMI_ACR_DROP_COUNT_EN
        want_drop = 8'd1;
`else
        want_drop = 8'd0;
`endif
        pif.clk_audio_counter_wrap = ~pif.clk_audio_counter_wrap;
        tick(1);
        total++; if (pif.acr_overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", pif.acr_overflow); else passed++;
        pif.clk_audio_counter_wrap = ~pif.clk_audio_counter_wrap;
        tick(2);
        total++; if (pif.acr_overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", pif.acr_overflow); else passed++;
        total++; if (pif.acr_drop_count !== want_drop) $display("FAIL ovf_drop got %0d want %0d", pif.acr_drop_count, want_drop); else passed++;
        pulse_enable();
        total++; if (pif.packet_type !== 3'd1 || pif.acr_overflow !== 1'b1)
            $display("FAIL ovf_sticky got type=%0d ovf=%b want 1/1", pif.packet_type, pif.acr_overflow);
        else passed++;
    endtask

    task automatic test_avi_period();
        logic [2:0] want [6] = '{3'd3, 3'd4, 3'd3, 3'd4, 3'd4, 3'd3};
        do_reset();
        for (int f = 0; f < 6; f++) begin
            pif.frame_start = 1'b1;
            tick(1);
            pif.frame_start = 1'b0;
            tick(2);
            pulse_enable();
            total++; if (pif.packet_type !== want[f])
                $display("FAIL avi_period_f%0d got type=%0d want %0d", f, pif.packet_type, want[f]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        pif.audio_req = 1'b1;
        pif.packet_enable = 1'b1;
        #2;
        reset = 1'b1;
        pif.clk_audio_counter_wrap = ~pif.clk_audio_counter_wrap;
        #1;
        total++; if (pif.packet_type !== 3'd0 || pif.header !== 24'h0 || pif.sub !== '0)
            $display("FAIL rst_mid_null got type=%0d hdr=%h want 0/000000", pif.packet_type, pif.header);
        else passed++;
        @(posedge clk);
        #1;
        pif.packet_enable = 1'b0;
        pif.audio_req = 1'b0;
        total++; if (pif.audio_ack !== 1'b0) $display("FAIL rst_mid_ack got %b want 0", pif.audio_ack); else passed++;
        reset = 1'b0;
        tick(3);
        total++; if (pif.audio_ack !== 1'b0 || pif.acr_overflow !== 1'b0)
            $display("FAIL rst_mid_after got ack=%b ovf=%b want 0/0", pif.audio_ack, pif.acr_overflow);
        else passed++;
        pulse_enable();
        total++; if (pif.packet_type !== 3'd3)
            $display("FAIL rst_mid_no_acr got type=%0d want 3", pif.packet_type);
        else passed++;
    endtask

    initial begin
        pif.clk_audio_counter_wrap = 1'b0;
        pif.audio_req     = 1'b0;
        pif.frame_start   = 1'b0;
        pif.packet_enable = 1'b0;
        pif.acr_header    = ACR_H;
        pif.acr_sub       = ACR_S;
        pif.audio_header  = AUD_H;
        pif.audio_sub     = AUD_S;
        pif.avi_header    = AVI_H;
        pif.avi_sub       = AVI_S;
        pif.aif_header    = AIF_H;
        pif.aif_sub       = AIF_S;

        test_reset();
        test_infoframes();
        test_acr();
        test_audio();
        test_overflow();
        test_avi_period();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
